ysyx_23060229_iter_shifter: RTL
===============================

Name: ysyx_23060229_iter_shifter

Overview:
Parametrised, multi-cycle logical, arithmetic and optionally rotate shifter for the EXU. It trades latency for area by shifting at most STEP bits per cycle. Operands are taken over a valid/ready handshake and the result is returned over a second valid/ready handshake, so the block can sit behind the issue stage as a variable-latency functional unit. It replaces the single-cycle SRA-only shifter and adds SLL/SRL, backpressure and flush.

Parameters:
XLEN, 32, datapath width; must be 32 or 64.
STEP, 8, maximum bits shifted per cycle; power of two, 1..XLEN.
SHAMT_W, $clog2(XLEN), derived localparam; not overridable.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
flush  in  1  synchronous pipeline flush; abandons any operation.
in_valid  in  1  operand valid.
in_ready  out  1  block can accept operands.
in_op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR (see Optional Feature).
in_src1  in  XLEN  value to be shifted.
in_shamt  in  SHAMT_W  shift amount; upper bits are already masked by the issuer.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
out_result  out  XLEN  shifted value.
busy  out  1  high in BUSY or DONE.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (async) forces: state IDLE, out_valid 0, out_result 0, busy 0, internal registers 0. in_ready = (state==IDLE) & ~flush, so in_ready is 1 while in reset.
- Accept: an accept occurs on a rising edge where in_valid & in_ready.
  - The block latches op, src1, remaining = in_shamt, and sign = in_src1[XLEN-1].
  - If in_shamt == 0, the next state is DONE with out_result = in_src1. Otherwise the next state is BUSY.
- BUSY, each cycle:
  - n = min(remaining, STEP).
  - work is shifted by n: SLL fills 0s; SRL fills 0s; SRA fills the latched sign bit.
  - remaining = remaining - n.
  - When the remainder reaches 0 on that edge, the state moves to DONE and out_result is updated.
- Latency from accept edge to out_valid visible = 1 + ceil(shamt/STEP) cycles. Examples: XLEN=32, STEP=8, shamt=31 gives 5; shamt=0 gives 1.
- DONE:
  - out_valid = 1.
  - out_result is held stable until an edge with out_ready, which returns the state to IDLE.
  - No new accept is possible in the same cycle; in_ready is low outside IDLE.
- out_result keeps its last value in IDLE; consumers qualify it with out_valid.
- Flush priority: flush has the highest priority after reset. On an edge with flush high, the next state is IDLE, out_valid drops, and any operand presented that cycle is not accepted.
- Simultaneous DONE & out_ready & flush resolves to IDLE; the result counts as consumed.
- Reset mid-operation discards all state; no partial result is ever presented.
- The result must equal the single-cycle reference semantics for every op/shamt/STEP combination. In particular, SRA of a negative value by XLEN-1 yields all ones.

Optional Feature:
- Macro: YSYX_23060229_SHIFT_ROTATE_EN.
- When defined, op 11 is ROR: each step rotates right by n, and the result equals (src1 >> shamt) | (src1 << (XLEN-shamt)), with shamt 0 returning src1 unchanged.
- When undefined, op 11 is reserved: the block forces remaining = 0, returns in_src1 unchanged with latency 1, and raises no error.

Decomposition:
- Package ysyx_23060229_shift_pkg holds:
  - op encoding localparams: SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROR.
  - FSM state typedef: IDLE, BUSY, DONE.
- One natural sub-module, ysyx_23060229_shift_step: a combinational single-step shifter.
  - Inputs: data, op, sign, n (0..STEP).
  - Output: data shifted by n.
  - It is instantiated once and holds the STEP-wide mux; the parent holds the FSM, counters and handshake.

Test Plan:
- SRA, src1=0x8000_0000, shamt=31, XLEN=32, STEP=8 -> out_result 0xFFFF_FFFF, out_valid exactly 5 cycles after accept.
- SLL, src1=0x0000_00F1, shamt=4 -> 0x0000_0F10 at latency 2. SRL, src1=0xF000_0000, shamt=28 -> 0x0000_000F at latency 5.
- shamt=0 on any op, src1=0x1234_5678 -> 0x1234_5678 at latency 1. Sweep STEP=1, 8, 32 with shamt=17 -> latencies 18, 4, 2 and identical results.
- Backpressure: out_ready held low 6 cycles in DONE -> out_valid and out_result stable; in_ready 0 throughout; IDLE one edge after out_ready rises.
- Flush asserted in the 2nd BUSY cycle and async reset pulsed mid-BUSY -> IDLE next edge/immediately, out_valid never asserted, next operation (SRL 0x8000_0000 by 1 -> 0x4000_0000) is correct.
- With YSYX_23060229_SHIFT_ROTATE_EN: ROR 0x0000_0001 by 1 -> 0x8000_0000. Without it: op 11 on 0xDEAD_BEEF -> 0xDEAD_BEEF at latency 1.

Source files
------------

// File: rtl/ysyx_23060229_shift_pkg.sv
// Shared definitions for the iterative shifter.
//   SHIFT_*        : 2-bit operation encodings presented on in_op
//   shift_state_e  : control FSM states
// Optional rotate support is selected by YSYX_23060229_SHIFT_ROTATE_EN
// (see ysyx_23060229_iter_shifter.sv).
package ysyx_23060229_shift_pkg;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } shift_state_e;

endpackage

// File: rtl/ysyx_23060229_shift_step.sv
// Combinational single-step shifter: shifts data by n (0..STEP) bits.
//   data   in  XLEN        value to shift
//   op     in  2           SLL / SRL / SRA / ROR encoding
//   sign   in  1           fill bit for SRA
//   n      in  NW          step amount, never larger than STEP
//   result out XLEN        shifted value
// Macro YSYX_23060229_SHIFT_ROTATE_EN enables the rotate case.
module ysyx_23060229_shift_step
  import ysyx_23060229_shift_pkg::*;
#(
  parameter  int XLEN = 32,
  parameter  int STEP = 8,
  localparam int NW   = $clog2(STEP + 1)
) (
  input  logic [XLEN-1:0] data,
  input  logic [1:0]      op,
  input  logic            sign,
  input  logic [NW-1:0]   n,
  output logic [XLEN-1:0] result
);

  // Every op is a slice of a 2*XLEN word {hi, data} shifted by n: the
  // upper half supplies the fill (zeros, sign copies or the data itself
  // for a rotate). Because n <= STEP this is only a STEP-wide mux.
  logic [XLEN-1:0]   hi;
  logic              left;
  logic [2*XLEN-1:0] shifted;

  always_comb begin
    hi   = '0;
    left = 1'b0;
    case (op)
      SHIFT_SLL: left = 1'b1;
      SHIFT_SRA: hi   = {XLEN{sign}};
`ifdef YSYX_23060229_SHIFT_ROTATE_EN
      SHIFT_ROR: hi   = data;
`endif
      default:   hi   = '0;
    endcase
    shifted = left ? ({hi, data} << n) : ({hi, data} >> n);
    result  = shifted[XLEN-1:0];
  end

endmodule

// File: rtl/ysyx_23060229_iter_shifter.sv
// Multi-cycle shifter for the EXU: shifts at most STEP bits per cycle.
//   clock, reset (async, active high), flush (sync abandon)
//   in_valid/in_ready, in_op, in_src1, in_shamt : operand handshake
//   out_valid/out_ready, out_result             : result handshake
//   busy                                        : high in BUSY or DONE
// Macro YSYX_23060229_SHIFT_ROTATE_EN: op 11 is rotate-right. When
// undefined, op 11 returns in_src1 unchanged with single-cycle latency.
module ysyx_23060229_iter_shifter
  import ysyx_23060229_shift_pkg::*;
#(
  parameter  int XLEN    = 32,
  parameter  int STEP    = 8,
  localparam int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [XLEN-1:0]    in_src1,
  input  logic [SHAMT_W-1:0] in_shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_result,
  output logic               busy
);

  localparam int NW = $clog2(STEP + 1);

  shift_state_e       state, state_nxt;
  logic [1:0]         op_q;
  logic               sign_q;
  logic [XLEN-1:0]    work;
  logic [SHAMT_W-1:0] rem, rem_nxt, acc_shamt;
  logic [NW-1:0]      n;
  logic [XLEN-1:0]    step_out;
  logic               accept;

  assign in_ready  = (state == IDLE) & ~flush;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

`ifdef YSYX_23060229_SHIFT_ROTATE_EN
  assign acc_shamt = in_shamt;
`else
  // Reserved op: a zero count sends it straight to DONE with src1.
  assign acc_shamt = (in_op == SHIFT_ROR) ? '0 : in_shamt;
`endif

  // n = min(rem, STEP); rem < STEP always fits in NW bits
  always_comb begin
    if (32'(rem) >= 32'(STEP)) n = NW'(STEP);
    else                       n = NW'(rem);
    rem_nxt = rem - SHAMT_W'(n);
  end

  ysyx_23060229_shift_step #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) u_step (
    .data   (work),
    .op     (op_q),
    .sign   (sign_q),
    .n      (n),
    .result (step_out)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = (acc_shamt == '0) ? DONE : BUSY;
        BUSY:    if (rem_nxt == '0) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath; a flush leaves registers alone since state alone gates use.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q       <= '0;
      sign_q     <= 1'b0;
      work       <= '0;
      rem        <= '0;
      out_result <= '0;
    end else if (!flush) begin
      if (accept) begin
        op_q   <= in_op;
        sign_q <= in_src1[XLEN-1];
        work   <= in_src1;
        rem    <= acc_shamt;
        if (acc_shamt == '0) out_result <= in_src1;
      end else if (state == BUSY) begin
        work <= step_out;
        rem  <= rem_nxt;
        if (rem_nxt == '0) out_result <= step_out;
      end
    end
  end

endmodule
